// File: rtl/led_status_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_status_pkg
//  Description : Shared definitions for the status-LED blinker: code width
//                and the 3-bit state encoding of the blink-code sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_status_pkg;

    // Width of the status code that is flashed on the code LED.
    localparam int CODE_W = 4;

    // Sequencer state encoding.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SYNC = 3'd1;
    localparam logic [2:0] ST_ON   = 3'd2;
    localparam logic [2:0] ST_OFF  = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_SYNC = ST_SYNC,
        S_ON   = ST_ON,
        S_OFF  = ST_OFF,
        S_GAP  = ST_GAP
    } state_t;

endpackage : led_status_pkg
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Free-running prescaler. Counts 0..CLK_FREQ/TICK_HZ-1 and
//                raises tick_o for exactly the cycle the count sits at max.
//  Ports       : clk    - fabric clock
//                rst_n  - asynchronous active-low reset
//                tick_o - one-cycle pulse at TICK_HZ
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int CLK_FREQ = 20000000,
    parameter int TICK_HZ  = 8
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    // Guards keep elaboration sane for illegal parameter sets; the top
    // module reports those with an elaboration error.
    localparam int c_DIV_RAW = (TICK_HZ > 0) ? (CLK_FREQ / TICK_HZ) : 1;
    localparam int c_DIV     = (c_DIV_RAW > 0) ? c_DIV_RAW : 1;
    localparam int c_CNT_W   = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_MAX = c_CNT_W'(c_DIV - 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (r_count == c_MAX) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    assign tick_o = (r_count == c_MAX);

endmodule : tick_gen
`default_nettype wire

// File: rtl/led_status_blinker.sv
`default_nettype none
// ============================================================================
//  Module      : led_status_blinker
//  Description : Board status-LED stage. Drives a 1 s heartbeat LED and a
//                blink-code LED that flashes a 4-bit code N times followed by
//                a dark pause. A fault input overrides the code display with
//                a flash that toggles on every slot tick.
//  Ports       : clk             - fabric clock, CLK_FREQ Hz
//                rst_n           - asynchronous active-low reset
//                code_i          - status code to blink (0..15)
//                code_valid_i    - code_i valid, held until accepted
//                code_ready_o    - block can accept a code
//                fault_i         - fault level, overrides code display
//                tick_o          - one-cycle slot pulse
//                led_heartbeat_o - toggles every TICK_HZ ticks
//                led_code_o      - blink-code / fault LED, 1 = lit
//                busy_o          - a code frame is in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module led_status_blinker
    import led_status_pkg::*;
#(
    parameter int CLK_FREQ  = 20000000,
    parameter int TICK_HZ   = 8,
    parameter int GAP_SLOTS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] code_i,
    input  logic              code_valid_i,
    output logic              code_ready_o,
    input  logic              fault_i,
    output logic              tick_o,
    output logic              led_heartbeat_o,
    output logic              led_code_o,
    output logic              busy_o
);

    localparam int c_TICK_SAFE = (TICK_HZ > 0) ? TICK_HZ : 1;
    localparam int c_HB_W      = (c_TICK_SAFE > 1) ? $clog2(c_TICK_SAFE) : 1;
    localparam logic [c_HB_W-1:0] c_HB_MAX = c_HB_W'(c_TICK_SAFE - 1);
    localparam int c_GAP_SAFE  = (GAP_SLOTS > 0) ? GAP_SLOTS : 1;
    localparam int c_GAP_W     = (c_GAP_SAFE > 1) ? $clog2(c_GAP_SAFE) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(c_GAP_SAFE - 1);

    generate
        if ((TICK_HZ == 0) || (GAP_SLOTS == 0) ||
            ((CLK_FREQ % c_TICK_SAFE) != 0)) begin : g_param_check
            $error("led_status_blinker: CLK_FREQ must be a multiple of TICK_HZ, TICK_HZ and GAP_SLOTS must be non-zero");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Slot tick
    // ------------------------------------------------------------------
    logic w_tick;

    tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .TICK_HZ  (TICK_HZ)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (w_tick)
    );

    assign tick_o = w_tick;

    // ------------------------------------------------------------------
    // Heartbeat: toggles on the tick that wraps the tick counter, so the
    // first toggle lands exactly one second after reset release.
    // ------------------------------------------------------------------
    logic [c_HB_W-1:0] r_hb_cnt;
    logic              r_heartbeat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hb_cnt    <= '0;
            r_heartbeat <= 1'b0;
        end else if (w_tick) begin
            if (r_hb_cnt == c_HB_MAX) begin
                r_hb_cnt    <= '0;
                r_heartbeat <= ~r_heartbeat;
            end else begin
                r_hb_cnt <= r_hb_cnt + c_HB_W'(1);
            end
        end
    end

    assign led_heartbeat_o = r_heartbeat;

    // ------------------------------------------------------------------
    // Blink-code sequencer
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic [CODE_W-1:0]   r_cnt;
    logic [CODE_W-1:0]   w_cnt_nxt;
    logic [c_GAP_W-1:0]  r_gap;
    logic [c_GAP_W-1:0]  w_gap_nxt;
    logic                r_led;
    logic                w_led_nxt;
    logic                r_fault_q;
    logic                w_xfer;

    assign code_ready_o = (r_state == S_IDLE) && !fault_i;
    assign w_xfer       = code_valid_i && code_ready_o;
    assign busy_o       = (r_state != S_IDLE);
    assign led_code_o   = r_led;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_gap     <= '0;
            r_led     <= 1'b0;
            r_fault_q <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gap     <= w_gap_nxt;
            r_led     <= w_led_nxt;
            r_fault_q <= fault_i;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap;
        w_led_nxt   = 1'b0;

        if (fault_i) begin
            // Fault aborts any frame; the flash starts dark on the first
            // fault cycle, then toggles on every slot tick.
            w_state_nxt = S_IDLE;
            w_led_nxt   = r_fault_q ? (r_led ^ w_tick) : 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        w_state_nxt = S_SYNC;
                        w_cnt_nxt   = code_i;
                    end
                end
                S_SYNC: begin
                    // Aligns the first lit slot to a full slot boundary.
                    if (w_tick) begin
                        w_gap_nxt   = '0;
                        w_state_nxt = (r_cnt == '0) ? S_GAP : S_ON;
                    end
                end
                S_ON: begin
                    if (w_tick) begin
                        w_state_nxt = S_OFF;
                        w_cnt_nxt   = r_cnt - CODE_W'(1);
                    end
                end
                S_OFF: begin
                    if (w_tick) begin
                        if (r_cnt == '0) begin
                            w_gap_nxt   = '0;
                            w_state_nxt = S_GAP;
                        end else begin
                            w_state_nxt = S_ON;
                        end
                    end
                end
                S_GAP: begin
                    if (w_tick) begin
                        if (r_gap == c_GAP_LAST) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_gap_nxt = r_gap + c_GAP_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
            w_led_nxt = (w_state_nxt == S_ON);
        end
    end

endmodule : led_status_blinker
`default_nettype wire

// File: tb/tb_led_status_blinker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_status_blinker
//  Description : Scoreboard bench for led_status_blinker (10 clk per slot,
//                2 gap slots). Expected per-slot LED values are queued when a
//                code is issued; a monitor pops one entry per slot tick while
//                the block is busy. Tick and heartbeat timing are predicted
//                from a cycle counter that restarts with reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_status_blinker;

    localparam int CLK_FREQ  = 80;
    localparam int TICK_HZ   = 8;
    localparam int GAP_SLOTS = 2;
    localparam int SLOT      = CLK_FREQ / TICK_HZ;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] code_i = 4'd0;
    logic       code_valid_i = 1'b0;
    logic       fault_i = 1'b0;
    logic       code_ready_o;
    logic       tick_o;
    logic       led_heartbeat_o;
    logic       led_code_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;
    int cyc;
    bit sb_q[$];
    bit m_exp;

    led_status_blinker #(
        .CLK_FREQ  (CLK_FREQ),
        .TICK_HZ   (TICK_HZ),
        .GAP_SLOTS (GAP_SLOTS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .code_i          (code_i),
        .code_valid_i    (code_valid_i),
        .code_ready_o    (code_ready_o),
        .fault_i         (fault_i),
        .tick_o          (tick_o),
        .led_heartbeat_o (led_heartbeat_o),
        .led_code_o      (led_code_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    // Cycles since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: timing model plus scoreboard pop on every busy slot tick.
    always @(negedge clk) begin
        if (rst_n) begin
            check("tick_o", tick_o, ((cyc % SLOT) == SLOT - 1) ? 1 : 0);
            check("heartbeat", led_heartbeat_o, (cyc / (SLOT * TICK_HZ)) % 2);
            if (tick_o && busy_o) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_slot_busy", busy_o, 0);
                end else begin
                    m_exp = sb_q.pop_front();
                    check("slot_led", led_code_o, m_exp);
                end
            end
        end
    end

    // One entry per slot: SYNC (dark), N x (lit, dark), GAP_SLOTS dark.
    task automatic push_frame(input int code);
        sb_q.push_back(1'b0);
        for (int i = 0; i < code; i++) begin
            sb_q.push_back(1'b1);
            sb_q.push_back(1'b0);
        end
        for (int i = 0; i < GAP_SLOTS; i++) sb_q.push_back(1'b0);
    endtask

    task automatic send(input int code);
        int n;
        @(negedge clk);
        code_i       = 4'(code);
        code_valid_i = 1'b1;
        push_frame(code);
        n = 0;
        while (!code_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_xfer", code_ready_o, 1);
        @(posedge clk);
        #1;
        code_valid_i = 1'b0;
        check("ready_after_xfer", code_ready_o, 0);
        check("busy_after_xfer", busy_o, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("frame_end_busy", busy_o, 0);
        check("frame_end_ready", code_ready_o, 1);
        check("frame_end_led", led_code_o, 0);
        check("scoreboard_drained", sb_q.size(), 0);
    endtask

    task automatic wait_led(input logic val, input int budget);
        int n;
        n = 0;
        while (led_code_o !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("led_wait", led_code_o, val);
    endtask

    initial begin
        int  n;
        bit  exp_led;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tick", tick_o, 0);
        check("rst_heartbeat", led_heartbeat_o, 0);
        check("rst_led", led_code_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ready", code_ready_o, 1);
        #2 rst_n = 1'b1;

        // 1: idle run, tick/heartbeat timing checked by the monitor
        repeat (200) begin
            @(negedge clk);
            check("idle_led", led_code_o, 0);
        end

        // 2: code 3
        send(3);
        wait_idle();

        // 3: code 0, empty frame
        send(0);
        wait_idle();

        // 4: code 5 aborted by fault in the second lit slot
        send(5);
        wait_led(1'b1, 100);
        wait_led(1'b0, 30);
        wait_led(1'b1, 30);
        fault_i      = 1'b1;
        code_i       = 4'd5;
        code_valid_i = 1'b1;
        sb_q.delete();
        #1;
        check("fault_ready", code_ready_o, 0);
        @(negedge clk);
        exp_led = 1'b0;
        repeat (40) begin
            check("fault_led", led_code_o, exp_led);
            check("fault_busy", busy_o, 0);
            check("fault_ready_hold", code_ready_o, 0);
            if ((cyc % SLOT) == SLOT - 1) exp_led = ~exp_led;
            @(negedge clk);
        end
        fault_i = 1'b0;
        push_frame(5);
        #1;
        check("post_fault_ready", code_ready_o, 1);
        @(posedge clk);
        #1;
        code_valid_i = 1'b0;
        check("post_fault_led", led_code_o, 0);
        check("post_fault_accept", busy_o, 1);
        wait_idle();

        // 5: transfer in the tick cycle
        n = 0;
        @(negedge clk);
        while ((cyc % SLOT) != SLOT - 1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        code_i       = 4'd2;
        code_valid_i = 1'b1;
        push_frame(2);
        check("xfer_on_tick_ready", code_ready_o, 1);
        check("xfer_on_tick_tick", tick_o, 1);
        @(posedge clk);
        #1;
        code_valid_i = 1'b0;
        n = 0;
        @(negedge clk);
        while (!led_code_o && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("sync_full_slot", n, SLOT);
        wait_idle();

        // 6: reset mid lit slot
        send(4);
        wait_led(1'b1, 100);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        sb_q.delete();
        check("arst_tick", tick_o, 0);
        check("arst_heartbeat", led_heartbeat_o, 0);
        check("arst_led", led_code_o, 0);
        check("arst_busy", busy_o, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (170) begin
            @(negedge clk);
            check("post_rst_led", led_code_o, 0);
            check("post_rst_busy", busy_o, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        checks++;
        errors++;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_led_status_blinker
`default_nettype wire
